// File: rtl/cdu_pkg.sv
// Shared types and constants for the CDU read-counter servo loop.
// Holds the loop state encoding and default step rates.
package cdu_pkg;

  localparam int LADDER_BITS    = 7;
  localparam int DEF_CNT_W      = 16;
  localparam int DEF_SLOW_DIV   = 8;
  localparam int DEF_FAST_DIV   = 2;
  localparam int DEF_SETTLE_CYC = 4;

  typedef enum logic [1:0] {
    HOLD,
    SLOW,
    FAST,
    SETTLE
  } cdu_state_e;

  typedef struct packed {
    logic f2;
    logic f1;
    logic sp;
  } cdu_flags_t;

  function automatic int max3(
    input int a,
    input int b,
    input int c
  );
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    return m;
  endfunction

endpackage

// File: rtl/cdu_sync2.sv
// Two-flop synchronizer for asynchronous threshold/sign flags.
// Synchronous active-low reset clears both stages.
module cdu_sync2 #(
  parameter int W = 1
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic [W-1:0] d_i,
  output logic [W-1:0] q_o
);

  logic [W-1:0] s1_q;
  logic [W-1:0] s2_q;

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      s1_q <= '0;
      s2_q <= '0;
    end else begin
      s1_q <= d_i;
      s2_q <= s1_q;
    end
  end

  assign q_o = s2_q;

endmodule

// File: rtl/cdu_read_counter_ctrl.sv
// Read-counter servo: steps the counter from coarse/fine error flags
// and drives the active-low ladder switches that null the error.
module cdu_read_counter_ctrl
  import cdu_pkg::*;
#(
  parameter int CNT_W      = DEF_CNT_W,
  parameter int SLOW_DIV   = DEF_SLOW_DIV,
  parameter int FAST_DIV   = DEF_FAST_DIV,
  parameter int SETTLE_CYC = DEF_SETTLE_CYC,
  parameter bit DIR_INV    = 1'b0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             _TLF1H,
  input  logic             _TLF2H,
  input  logic             _ERRP,
  input  logic             zero,
  output logic [CNT_W-1:0] count,
  output logic             up_pulse,
  output logic             dn_pulse,
  output logic             _D15,
  output logic             _D16,
  output logic             _D17,
  output logic             _D18,
  output logic             _D19,
  output logic             _D20,
  output logic             _D21
);

  localparam int DIV_MAX = max3(SLOW_DIV, FAST_DIV, SETTLE_CYC);
  localparam int DIV_W   = $clog2(DIV_MAX + 1);

  localparam logic [DIV_W-1:0] SLOW_LAST   = DIV_W'(SLOW_DIV - 1);
  localparam logic [DIV_W-1:0] FAST_LAST   = DIV_W'(FAST_DIV - 1);
  localparam logic [DIV_W-1:0] SETTLE_LAST = DIV_W'(SETTLE_CYC - 1);

  cdu_flags_t       flags;
  cdu_state_e       state_q, state_d;
  logic [DIV_W-1:0] div_q, div_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             dir_q, dir_d;
  logic             up_q, up_d;
  logic             dn_q, dn_d;
  logic             dir_live;
  logic             step_up;
  logic             step_dn;

  cdu_sync2 #(
    .W($bits(cdu_flags_t))
  ) u_sync (
    .clk_i (clk),
    .rst_ni(rst_n),
    .d_i   ({_TLF2H, _TLF1H, _ERRP}),
    .q_o   (flags)
  );

  assign dir_live = flags.sp ^ DIR_INV;

  always_comb begin
    state_d = state_q;
    div_d   = div_q;
    dir_d   = dir_q;
    step_up = 1'b0;
    step_dn = 1'b0;
    unique case (state_q)
      HOLD: begin
        div_d = '0;
        if (flags.f2) begin
          state_d = FAST;
          dir_d   = dir_live;
        end else if (flags.f1) begin
          state_d = SLOW;
          dir_d   = dir_live;
        end
      end
      SLOW: begin
        if (div_q == SLOW_LAST) begin
          state_d = SETTLE;
          div_d   = '0;
          step_up = dir_q;
          step_dn = ~dir_q;
        end else begin
          div_d = div_q + 1'b1;
        end
      end
      FAST: begin
        // Exit wins over a due step so the loop never overshoots.
        if (!flags.f2 || (dir_live != dir_q)) begin
          state_d = SETTLE;
          div_d   = '0;
        end else if (div_q == FAST_LAST) begin
          div_d   = '0;
          step_up = dir_q;
          step_dn = ~dir_q;
        end else begin
          div_d = div_q + 1'b1;
        end
      end
      SETTLE: begin
        if (div_q == SETTLE_LAST) begin
          state_d = HOLD;
          div_d   = '0;
        end else begin
          div_d = div_q + 1'b1;
        end
      end
      default: begin
        state_d = HOLD;
        div_d   = '0;
      end
    endcase
    if (zero) begin
      state_d = HOLD;
      div_d   = '0;
      step_up = 1'b0;
      step_dn = 1'b0;
    end
  end

  always_comb begin
    cnt_d = cnt_q;
    unique case (1'b1)
      zero:    cnt_d = '0;
      step_up: cnt_d = cnt_q + 1'b1;
      step_dn: cnt_d = cnt_q - 1'b1;
      default: cnt_d = cnt_q;
    endcase
    up_d = step_up;
    dn_d = step_dn;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= HOLD;
      div_q   <= '0;
      cnt_q   <= '0;
      dir_q   <= 1'b0;
      up_q    <= 1'b0;
      dn_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      div_q   <= div_d;
      cnt_q   <= cnt_d;
      dir_q   <= dir_d;
      up_q    <= up_d;
      dn_q    <= dn_d;
    end
  end

  logic [LADDER_BITS-1:0] ladder_n;

  assign ladder_n = ~cnt_q[LADDER_BITS-1:0];

  assign count    = cnt_q;
  assign up_pulse = up_q;
  assign dn_pulse = dn_q;
  assign _D21     = ladder_n[0];
  assign _D20     = ladder_n[1];
  assign _D19     = ladder_n[2];
  assign _D18     = ladder_n[3];
  assign _D17     = ladder_n[4];
  assign _D16     = ladder_n[5];
  assign _D15     = ladder_n[6];

endmodule

// File: tb/tb_cdu_read_counter_ctrl.sv
// Randomized bench for cdu_read_counter_ctrl against a
// countdown-style behavioural model of the servo loop.
module tb_cdu_read_counter_ctrl;

  localparam int SLOW_DIV   = 8;
  localparam int FAST_DIV   = 2;
  localparam int SETTLE_CYC = 4;
  localparam bit DIR_INV    = 1'b0;

  localparam int M_IDLE = 0;
  localparam int M_SLOW = 1;
  localparam int M_FAST = 2;
  localparam int M_WAIT = 3;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        tlf1, tlf2, errp, zero;
  logic [15:0] count;
  logic        up, dn;
  logic        d15, d16, d17, d18, d19, d20, d21;

  int nvec = 0;
  int nbad = 0;

  bit [2:0] hist [3];
  int m_mode;
  int m_rem;
  bit m_lat;
  int m_cnt;
  bit m_up, m_dn;

  cdu_read_counter_ctrl #(
    .CNT_W     (16),
    .SLOW_DIV  (SLOW_DIV),
    .FAST_DIV  (FAST_DIV),
    .SETTLE_CYC(SETTLE_CYC),
    .DIR_INV   (DIR_INV)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    ._TLF1H  (tlf1),
    ._TLF2H  (tlf2),
    ._ERRP   (errp),
    .zero    (zero),
    .count   (count),
    .up_pulse(up),
    .dn_pulse(dn),
    ._D15    (d15),
    ._D16    (d16),
    ._D17    (d17),
    ._D18    (d18),
    ._D19    (d19),
    ._D20    (d20),
    ._D21    (d21)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] want);
    nvec++;
    if (got !== want) begin
      nbad++;
      $display("FAIL %s: got %0h want %0h at %0t", tag, got, want, $time);
    end
  endtask

  // Effect of one rising edge on the model, given the inputs now driven.
  task automatic model_edge();
    bit fc, ff, sg, want_up;
    int sd;
    hist[2] = hist[1];
    hist[1] = hist[0];
    hist[0] = {tlf2, tlf1, errp};
    fc = hist[2][2];
    ff = hist[2][1];
    sg = hist[2][0];
    want_up = sg ^ DIR_INV;
    sd = 0;
    if (!rst_n) begin
      m_cnt = 0;
      m_mode = M_IDLE;
      hist[0] = 3'b0;
      hist[1] = 3'b0;
      hist[2] = 3'b0;
    end else if (zero) begin
      m_cnt = 0;
      m_mode = M_IDLE;
    end else begin
      case (m_mode)
        M_IDLE: begin
          if (fc) begin
            m_mode = M_FAST; m_rem = FAST_DIV; m_lat = want_up;
          end else if (ff) begin
            m_mode = M_SLOW; m_rem = SLOW_DIV; m_lat = want_up;
          end
        end
        M_SLOW: begin
          m_rem--;
          if (m_rem == 0) begin
            sd = m_lat ? 1 : -1;
            m_mode = M_WAIT;
            m_rem = SETTLE_CYC;
          end
        end
        M_FAST: begin
          if (!fc || want_up != m_lat) begin
            m_mode = M_WAIT;
            m_rem = SETTLE_CYC;
          end else begin
            m_rem--;
            if (m_rem == 0) begin
              sd = m_lat ? 1 : -1;
              m_rem = FAST_DIV;
            end
          end
        end
        default: begin
          m_rem--;
          if (m_rem == 0) m_mode = M_IDLE;
        end
      endcase
      m_cnt = (m_cnt + sd + 65536) % 65536;
    end
    m_up = (sd > 0);
    m_dn = (sd < 0);
  endtask

  task automatic cyc();
    logic [15:0] e;
    model_edge();
    @(posedge clk);
    @(negedge clk);
    e = m_cnt[15:0];
    chk("count", {16'h0, count}, {16'h0, e});
    chk("up", {31'h0, up}, {31'h0, m_up});
    chk("dn", {31'h0, dn}, {31'h0, m_dn});
    chk("ladder", {25'h0, d15, d16, d17, d18, d19, d20, d21},
        {25'h0, ~e[6:0]});
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    tlf1 = 1'b0; tlf2 = 1'b0; errp = 1'b0; zero = 1'b0;
    cyc();
    rst_n = 1'b1;
  endtask

  initial begin
    int ups;
    int n;
    m_mode = M_IDLE; m_rem = 0; m_lat = 1'b0; m_cnt = 0;
    m_up = 1'b0; m_dn = 1'b0;
    for (int i = 0; i < 3; i++) hist[i] = 3'b0;

    // Reset and quiet idle
    do_reset();
    chk("rst_count", {16'h0, count}, 32'h0);
    chk("rst_ladder", {25'h0, d15, d16, d17, d18, d19, d20, d21}, 32'h7f);
    for (int i = 0; i < 50; i++) cyc();

    // Slow up-counting with fine flag
    tlf1 = 1'b1; errp = 1'b1;
    ups = 0;
    for (int i = 0; i < 37; i++) begin
      cyc();
      if (up) ups++;
    end
    chk("slow_cnt3", {16'h0, count}, 32'h3);
    chk("slow_d21", {31'h0, d21}, 32'h0);
    chk("slow_d20", {31'h0, d20}, 32'h0);
    chk("slow_ups", ups, 3);

    // Fast down-counting wraps below zero
    do_reset();
    tlf2 = 1'b1; errp = 1'b0;
    for (int i = 0; i < 5; i++) cyc();
    chk("fast_wrap", {16'h0, count}, 32'hffff);
    for (int i = 0; i < 18; i++) cyc();
    chk("fast_10", {16'h0, count}, 32'hfff6);

    // Direction reversal during FAST
    do_reset();
    tlf2 = 1'b1; errp = 1'b1;
    for (int i = 0; i < 11; i++) cyc();
    errp = 1'b0;
    for (int i = 0; i < 20; i++) cyc();

    // Zero pulse mid-FAST at 0x40
    do_reset();
    tlf2 = 1'b1; errp = 1'b1;
    n = 0;
    while (m_cnt != 16'h40 && n < 500) begin
      cyc();
      n++;
    end
    chk("reach_40", {16'h0, count}, 32'h40);
    zero = 1'b1;
    cyc();
    zero = 1'b0;
    chk("zero_clr", {16'h0, count}, 32'h0);
    for (int i = 0; i < 20; i++) cyc();

    // Reset during SETTLE at 0x1234
    do_reset();
    tlf2 = 1'b1; errp = 1'b1;
    n = 0;
    while (m_cnt != 16'h1233 && n < 12000) begin
      cyc();
      n++;
    end
    tlf2 = 1'b0;
    for (int i = 0; i < 3; i++) cyc();
    chk("settle_1234", {16'h0, count}, 32'h1234);
    rst_n = 1'b0;
    cyc();
    rst_n = 1'b1;
    chk("rst_mid", {16'h0, count}, 32'h0);
    chk("rst_mid_lad", {25'h0, d15, d16, d17, d18, d19, d20, d21}, 32'h7f);
    tlf1 = 1'b1; errp = 1'b1;
    for (int i = 0; i < 30; i++) cyc();

    // Randomized segments
    for (int s = 0; s < 80; s++) begin
      tlf1 = 1'($urandom_range(0, 1));
      tlf2 = 1'($urandom_range(0, 1));
      errp = 1'($urandom_range(0, 1));
      n = $urandom_range(1, 40);
      for (int i = 0; i < n; i++) begin
        zero = ($urandom_range(0, 49) == 0);
        rst_n = !($urandom_range(0, 199) == 0);
        if ($urandom_range(0, 9) == 0) errp = ~errp;
        cyc();
      end
    end
    zero = 1'b0;
    rst_n = 1'b1;

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nbad);
    $finish;
  end

endmodule

// File: doc/cdu_read_counter_ctrl.md
Name: cdu_read_counter_ctrl

Overview:
- Digital read-counter loop closing the fine-error servo downstream of the main summing amplifier / error Schmitt triggers.
- Consumes the coarse (_TLF2H) and fine (_TLF1H) threshold flags plus error sign, steps a binary read counter up/down at fast or slow rate, and emits one-cycle count pulses toward the computer interface.
- Its low 7 counter bits drive the active-low ladder-switch lines _D15.._D21 back into the summing amplifier, nulling the error.

Parameters:
CNT_W, 16, read counter width (>= 7)
SLOW_DIV, 8, cycles per step in SLOW state (>= 1)
FAST_DIV, 2, cycles per step in FAST state (>= 1)
SETTLE_CYC, 4, wait cycles after a SLOW step or a FAST exit, for analog settling (>= 1)
DIR_INV, 0, 1 = invert sign-to-direction mapping

Ports:
clk  in  1  system clock, all logic on rising edge
rst_n  in  1  synchronous active-low reset
_TLF1H  in  1  fine-error threshold exceeded (high = exceeded), asynchronous
_TLF2H  in  1  coarse-error threshold exceeded (high = exceeded), asynchronous
_ERRP  in  1  error sign, high = positive, asynchronous
zero  in  1  synchronous counter clear, active high
count  out  CNT_W  read counter value
up_pulse  out  1  one-cycle pulse per increment
dn_pulse  out  1  one-cycle pulse per decrement
_D15.._D21  out  1 each  active-low ladder bits: _D21 = ~count[0] ... _D15 = ~count[6]

Behaviour:
- Reset (rst_n low at an edge): count=0, state HOLD, dividers 0, up_pulse=dn_pulse=0, all _D high, synchronizer flops 0. Reset overrides everything.
- _TLF1H, _TLF2H, _ERRP each pass a 2-flop synchronizer. Only synced versions (f1, f2, sp) are used. Input-to-logic latency is 2 edges.
- dir_up = sp XOR DIR_INV.
- States:
  - HOLD: if f2, go FAST; else if f1, go SLOW; else stay. Latch dir_up on the transition. Clear the divider.
  - SLOW: divider counts 0..SLOW_DIV-1. At SLOW_DIV-1, step once and go SETTLE.
  - FAST: divider counts 0..FAST_DIV-1. At FAST_DIV-1, step and restart the divider.
    - Exit to SETTLE on any edge where f2=0 or the live dir_up differs from the latched direction.
    - The exit check has priority; no step on the exit edge.
  - SETTLE: count SETTLE_CYC cycles, then go HOLD. f1, f2 and sp are ignored meanwhile.
- Step: count <= count ± 1, modulo 2^CNT_W (0xFFFF+1 wraps to 0; 0-1 wraps to 0xFFFF).
  - Direction pulse is registered high in the same cycle the new count appears.
  - Pulses are never both high, and never high for two consecutive cycles from a SLOW step.
- zero=1 at an edge (rst_n high): count=0, state HOLD, divider 0, no pulse that cycle. zero beats a coincident step.
- _D outputs are combinational inversions of the registered count, so they have no extra latency.
- SLOW loop period with f1 held high: 1 (HOLD) + SLOW_DIV + SETTLE_CYC = 13 cycles per step at defaults.

Decomposition:
- Shared package cdu_pkg holds:
  - state enum {HOLD, SLOW, FAST, SETTLE}
  - LADDER_BITS=7 constant
  - default rate constants
- One sub-module: cdu_sync2 (parameterized-width 2-flop synchronizer, reset to 0), instantiated once for the 3-bit input bundle.

Test Plan:
1. Assert reset, then release. -> count=0, _D15.._D21 all 1, up/dn 0, no activity with all inputs low for 50 cycles.
2. Hold _TLF1H=1, _ERRP=1 from count 0.
   - First step arrives 2 (sync) + 1 + 8 edges after the first sampling edge.
   - Later steps come every 13 cycles.
   - After 3 steps: count=3, _D21=0, _D20=0, exactly 3 up_pulses.
3. Hold _TLF2H=1, _ERRP=0 from count 0.
   - First step gives count=0xFFFF with a dn_pulse.
   - Further steps every 2 cycles; after 10 steps count=0xFFF6.
4. In FAST counting up, toggle _ERRP to 0 with _TLF2H held.
   - 2 edges after the toggle: SETTLE, no step.
   - 4 cycles later: HOLD, then FAST down.
   - The first dn_pulse follows FAST_DIV cycles later.
5. Pulse zero for one cycle mid-FAST at count=0x0040. -> count=0 next edge, state HOLD, no pulse that cycle; counting resumes from 0.
6. Drive rst_n low for one edge during SETTLE with count=0x1234. -> count=0, all _D=1, state HOLD, synchronizers cleared; the next step occurs only after fresh input sampling.
